fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Desc     : Instruction fetch: PC, I$ lookup, miss refill from DRAM, simple
//            static branch prediction, instruction FIFO toward dispatch.
//            Define IFU_STATIC_BTFN_EN for backward-taken/forward-not-taken.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    BLOCK_SIZE  = 64,
    parameter int                    IFIFO_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic [ADDR_WIDTH-1:0]  recovery_PC,
    input  logic                   recovery_PC_valid,
    input  logic                   backend_stall,
    output logic [ADDR_WIDTH-1:0]  icache_addr,
    input  logic                   icache_hit,
    input  logic [BLOCK_SIZE-1:0]  icache_rdata,
    output logic                   icache_fill_we,
    output logic [ADDR_WIDTH-1:0]  icache_fill_addr,
    output logic [BLOCK_SIZE-1:0]  icache_fill_data,
    output logic                   dram_req_valid,
    input  logic                   dram_req_ready,
    output logic [ADDR_WIDTH-1:0]  dram_req_addr,
    input  logic                   dram_resp_valid,
    input  logic [BLOCK_SIZE-1:0]  dram_resp_data,
    input  logic                   dispatch_ready,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_is_cond_br,
    output logic                   instr_pred_taken,
    output logic [ADDR_WIDTH-1:0]  instr_target
);

    localparam int c_words = BLOCK_SIZE / INSTR_WIDTH;
    localparam int c_off_w = $clog2(BLOCK_SIZE / 8);
    localparam int c_ptr_w = $clog2(IFIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [ADDR_WIDTH-1:0] c_block_mask = ~ADDR_WIDTH'(BLOCK_SIZE / 8 - 1);
    localparam logic [c_cnt_w-1:0]    c_full_count = c_cnt_w'(IFIFO_DEPTH);
    localparam logic [6:0]            c_op_jal     = 7'b1101111;
    localparam logic [6:0]            c_op_branch  = 7'b1100011;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        FILL      = 2'd3
    } state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
        logic                   is_cond_br;
        logic                   pred_taken;
        logic [ADDR_WIDTH-1:0]  target;
    } fifo_entry_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_miss_addr;
    logic [BLOCK_SIZE-1:0]   r_fill_data;
    fifo_entry_t             r_fifo_mem [IFIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;

    logic [INSTR_WIDTH-1:0]  w_instr;
    logic [ADDR_WIDTH-1:0]   w_imm_b;
    logic [ADDR_WIDTH-1:0]   w_imm_j;
    logic [ADDR_WIDTH-1:0]   w_pc_plus4;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic [ADDR_WIDTH-1:0]   w_next_pc;
    logic                    w_is_jal;
    logic                    w_is_cond_br;
    logic                    w_pred_taken;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_enq;
    logic                    w_deq;
    logic                    w_miss;
    fifo_entry_t             w_entry;
    fifo_entry_t             w_head;

    assign icache_addr = r_pc;

    generate
        if (c_words > 1) begin : g_multi_word
            logic [INSTR_WIDTH-1:0] w_words [c_words];
            for (genvar gi = 0; gi < c_words; gi++) begin : g_word
                assign w_words[gi] = icache_rdata[gi*INSTR_WIDTH +: INSTR_WIDTH];
            end
            assign w_instr = w_words[r_pc[c_off_w-1:2]];
        end else begin : g_single_word
            assign w_instr = icache_rdata[INSTR_WIDTH-1:0];
        end
    endgenerate

    // RISC-V B/J immediates, sign-extended to the address width
    assign w_imm_b = {{(ADDR_WIDTH-12){w_instr[31]}}, w_instr[7], w_instr[30:25],
                      w_instr[11:8], 1'b0};
    assign w_imm_j = {{(ADDR_WIDTH-20){w_instr[31]}}, w_instr[19:12], w_instr[20],
                      w_instr[30:21], 1'b0};

    assign w_is_jal     = (w_instr[6:0] == c_op_jal);
    assign w_is_cond_br = (w_instr[6:0] == c_op_branch);

`ifdef IFU_STATIC_BTFN_EN
    assign w_pred_taken = w_is_cond_br & w_instr[31];
`else
    assign w_pred_taken = 1'b0;
`endif

    assign w_pc_plus4 = r_pc + ADDR_WIDTH'(4);
    assign w_target   = w_is_jal     ? r_pc + w_imm_j :
                        w_is_cond_br ? r_pc + w_imm_b : w_pc_plus4;
    assign w_next_pc  = (w_is_jal || w_pred_taken) ? w_target : w_pc_plus4;

    assign w_entry = {w_instr, r_pc, w_is_cond_br, w_pred_taken, w_target};

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_state_nxt    = r_state;
        dram_req_valid = 1'b0;
        icache_fill_we = 1'b0;
        w_enq          = 1'b0;
        w_miss         = 1'b0;
        case (r_state)
            RUN: begin
                if (!recovery_PC_valid) begin
                    if (!icache_hit) begin
                        w_miss      = 1'b1;
                        w_state_nxt = MISS_REQ;
                    end else if (!backend_stall && !w_full) begin
                        w_enq = 1'b1;
                    end
                end
            end
            MISS_REQ: begin
                dram_req_valid = 1'b1;
                if (dram_req_ready) w_state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (dram_resp_valid) w_state_nxt = FILL;
            end
            FILL: begin
                icache_fill_we = 1'b1;
                w_state_nxt    = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
        if (!rst_aL) begin
            dram_req_valid = 1'b0;
            icache_fill_we = 1'b0;
            w_enq          = 1'b0;
            w_miss         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            r_state     <= RUN;
            r_pc        <= RESET_PC;
            r_miss_addr <= '0;
            r_fill_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Redirect wins over everything, but an in-flight refill still completes
            if (recovery_PC_valid) begin
                r_pc <= recovery_PC;
            end else if (w_enq) begin
                r_pc <= w_next_pc;
            end
            if (w_miss) begin
                r_miss_addr <= r_pc & c_block_mask;
            end
            if (r_state == MISS_WAIT && dram_resp_valid) begin
                r_fill_data <= dram_resp_data;
            end
        end
    end

    assign dram_req_addr    = r_miss_addr;
    assign icache_fill_addr = r_miss_addr;
    assign icache_fill_data = r_fill_data;

    // Head is only visible from the registered FIFO: no enqueue bypass
    assign instr_valid = rst_aL && !w_empty && !recovery_PC_valid;
    assign w_deq       = instr_valid && dispatch_ready;

    always_ff @(posedge clk) begin
        if (!rst_aL || recovery_PC_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head           = r_fifo_mem[r_rd_ptr];
    assign instr_data       = w_head.instr;
    assign instr_pc         = w_head.pc;
    assign instr_is_cond_br = w_head.is_cond_br;
    assign instr_pred_taken = w_head.pred_taken;
    assign instr_target     = w_head.target;

endmodule
`default_nettype wire
